braun_mult_arbiter: RTL and testbench
=====================================

BRAUN_MULT_ARBITER -- requirements
Module: braun_mult_arbiter

Interface
REQ-001 SHALL have parameter: N, 8, operand width in bits (N >= 2).
REQ-002 SHALL have ports, in this order:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  per-requester operand valid
- req_ready  output  4  per-requester accept strobe, at most one bit set
- req_a  input  4*N  operand A; requester i occupies bits [i*N +: N]
- req_b  input  4*N  operand B; same packing as req_a
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_p  output  2*N  product
- res_id  output  2  index of requester that owns res_p
- busy  output  1  high whenever state is not IDLE

Function
REQ-003 SHALL share one multiplier among 4 requesters, one operation in flight at a time.
REQ-004 SHALL implement FSM states:
- IDLE: waiting for a request
- CALC: operands registered, product computing
- DONE: result held for consumer
REQ-005 IDLE, any req_valid high: SHALL assert req_ready on exactly one granted requester (combinational, same cycle), register its a, b and index, and go to CALC.
REQ-006 Grant SHALL be round-robin: the first valid requester at or after rr_ptr, searching upward modulo 4.
REQ-007 rr_ptr SHALL be set to (granted index + 1) mod 4 on each grant; 3 SHALL wrap to 0.
REQ-008 req_ready SHALL be all-zero in CALC and DONE, and in IDLE when no req_valid is high.
REQ-009 CALC SHALL register the full 2*N-bit unsigned product into res_p, then go to DONE unconditionally.
REQ-010 The product SHALL be exact, with no truncation; (2^N-1)*(2^N-1) SHALL fit in res_p.
REQ-011 DONE SHALL hold res_valid=1, with res_p and res_id stable until res_ready is high at a rising edge, then go to IDLE.
REQ-012 Latency SHALL be: accept at edge t, res_valid high from edge t+2; minimum issue interval 3 cycles with res_ready tied high.
REQ-013 A new request SHALL NOT be accepted in the cycle the result is consumed; acceptance resumes in the following IDLE cycle.
REQ-014 req_valid changes during CALC or DONE SHALL have no effect on the operation in flight.
REQ-015 res_valid SHALL be low in IDLE and CALC; res_p and res_id SHALL hold their last values outside DONE.

Reset
REQ-016 While rst is high at a rising edge, the block SHALL enter IDLE from any state, abandoning any operation in flight with no result emitted.
REQ-017 Reset values SHALL be: rr_ptr=0, res_valid=0, res_p=0, res_id=0, req_ready=0, busy=0.
REQ-018 The first cycle after rst deasserts SHALL be able to grant.

Structure
REQ-019 State encodings (IDLE/CALC/DONE) and the requester-count constant 4 SHALL live in a shared package braun_pkg.
REQ-020 The product SHALL be computed by one instance of the existing Braun array multiplier sub-module braun_multiplier with n=N, fed from the operand registers.
REQ-021 No other sub-modules; arbiter and FSM SHALL be in this module.

Verification (N=8)
REQ-022 Single request: requester 2 gives a=13, b=11; res_ready=1 -> req_ready=4'b0100 at t, res_valid at t+2, res_p=143, res_id=2.
REQ-023 All four valid, res_ready=1, after reset -> grants in order 0,1,2,3,0, one every 3 cycles; rr_ptr wraps 3->0.
REQ-024 Max operands: a=255, b=255 -> res_p=65025; and a=0, b=200 -> res_p=0.
REQ-025 Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_p, res_id stable, req_ready=0 throughout; on release, next grant one cycle later.
REQ-026 Reset mid-operation: rst asserted in CALC -> next cycle IDLE, res_valid=0, rr_ptr=0, no result emitted.
REQ-027 Fairness: requesters 1 and 3 held valid continuously -> alternating grants 1,3,1,3; neither starved.

Source files
------------

// File: rtl/braun_pkg.sv
// Shared definitions for the Braun multiplier arbiter: FSM encoding,
// requester count and the round-robin pick helper.
package braun_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // First valid requester at or after ptr, searching upward modulo NUM_REQ.
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/braun_multiplier.sv
// Unsigned n x n Braun array multiplier: carry-save rows of full adders
// followed by a ripple-carry vector-merging row for the upper half.
module braun_multiplier #(
  parameter int n = 8
) (
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [2*n-1:0] p
);

  logic [n-1:0][n-1:0] row_s;
  logic [n-1:0][n-1:0] row_c;
  logic [n-1:0]        upper;
  logic                x;
  logic                y;
  logic                z;
  logic                carry;

  always_comb begin
    row_s = '0;
    row_c = '0;
    upper = '0;
    p     = '0;
    x     = 1'b0;
    y     = 1'b0;
    z     = 1'b0;
    carry = 1'b0;

    for (int j = 0; j < n; j++) row_s[0][j] = a[j] & b[0];

    // Row i adds partial product i to the previous row's sums (shifted
    // down one column) and carries, all at weight i+j.
    for (int i = 1; i < n; i++) begin
      upper = row_s[i-1] >> 1;
      for (int j = 0; j < n; j++) begin
        x = a[j] & b[i];
        y = upper[j];
        z = row_c[i-1][j];
        row_s[i][j] = x ^ y ^ z;
        row_c[i][j] = (x & y) | (x & z) | (y & z);
      end
    end

    for (int i = 0; i < n; i++) p[i] = row_s[i][0];

    upper = row_s[n-1] >> 1;
    for (int k = 0; k < n; k++) begin
      x = upper[k];
      y = row_c[n-1][k];
      p[n+k] = x ^ y ^ carry;
      carry  = (x & y) | (x & carry) | (y & carry);
    end
  end

endmodule

// File: rtl/braun_mult_arbiter.sv
// Four requesters share one Braun multiplier through a round-robin
// arbiter; one operation in flight, IDLE -> CALC -> DONE.
module braun_mult_arbiter
  import braun_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*N-1:0]       res_p,
  output logic [1:0]           res_id,
  output logic                 busy
);

  // Handshakes: a request transfers on the edge where req_valid[i] and
  // req_ready[i] are both high; a result transfers on the edge where
  // res_valid and res_ready are both high. req_ready is only offered in IDLE.

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     rr_ptr;
  logic [1:0]     grant_idx;
  logic           grant;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [1:0]     id_q;
  logic [2*N-1:0] prod;

  braun_multiplier #(.n(N)) u_mult (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant     = 1'b0;
    grant_idx = rr_pick(req_valid, rr_ptr);
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant     = 1'b1;
          req_ready = NUM_REQ'(1) << grant_idx;
          state_nxt = CALC;
        end
      end
      CALC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      res_p  <= '0;
      res_id <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        a_q    <= req_a[grant_idx*N +: N];
        b_q    <= req_b[grant_idx*N +: N];
        id_q   <= grant_idx;
        rr_ptr <= grant_idx + 2'd1;
      end
      // Result registers only move on leaving CALC, so they hold elsewhere.
      if (state == CALC) begin
        res_p  <= prod;
        res_id <= id_q;
      end
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_braun_mult_arbiter.sv
// Bench for braun_mult_arbiter: vector table, round-robin/fairness,
// backpressure and mid-operation reset sequences, with a result scoreboard.
module tb_braun_mult_arbiter;

  localparam int N = 8;
  localparam int W = 2*N + 2;

  logic           clk;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [2*N-1:0] res_p;
  logic [1:0]     res_id;
  logic           busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] exp_q[$];

  braun_mult_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: event did not occur within bound at %0t", name, $time);
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int model_pick(input logic [3:0] v, input int ptr);
    for (int off = 0; off < 4; off++) if (v[(ptr + off) % 4]) return (ptr + off) % 4;
    return -1;
  endfunction

  // driver tasks
  task automatic set_lane(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
  endtask

  task automatic wait_grant(output int idx, output int waited);
    idx = -1;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      waited++;
      if (req_ready != 4'b0) begin
        idx = onehot_idx(req_ready);
        break;
      end
    end
    if (idx < 0) fail_now("grant_timeout");
  endtask

  task automatic wait_result();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("result_timeout");
  endtask

  // scoreboard / monitor: predicts grants, pushes expected products, pops on handshake
  int           model_ptr = 0;
  int           cyc = 0;
  int           grant_cyc = 0;
  logic         prev_valid = 1'b0;

  always @(negedge clk) begin
    int           g;
    logic [W-1:0] e;
    logic [2*N-1:0] pa;
    logic [2*N-1:0] pb;
    cyc++;
    if (rst) begin
      model_ptr = 0;
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (exp_q.size() == 0) check("res_valid_no_op", {31'b0, res_valid}, 0);
      if (busy) check("ready_while_busy", {28'b0, req_ready}, 0);
      if (req_ready != 4'b0) begin
        g = model_pick(req_valid, model_ptr);
        check("grant_model", {28'b0, req_ready}, (g < 0) ? 0 : (32'd1 << g));
        if (g >= 0) begin
          model_ptr = (g + 1) % 4;
          pa = (2*N)'(req_a[g*N +: N]);
          pb = (2*N)'(req_b[g*N +: N]);
          exp_q.push_back({2'(g), pa * pb});
          grant_cyc = cyc;
        end
      end
      if (res_valid && !prev_valid) check("latency", cyc - grant_cyc, 2);
      if (res_valid && res_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_p", {16'b0, res_p}, {16'b0, e[2*N-1:0]});
        check("sb_id", {30'b0, res_id}, {30'b0, e[W-1:2*N]});
      end
      prev_valid = res_valid;
    end
  end

  typedef struct {
    int             id;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int idx;
    int waited;
    realtime t_prev;
    logic [2*N-1:0] held_p;

    vecs[0] = '{2, 8'd13,  8'd11,  16'd143};
    vecs[1] = '{0, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{1, 8'd0,   8'd200, 16'd0};
    vecs[3] = '{3, 8'd1,   8'd1,   16'd1};
    vecs[4] = '{2, 8'd128, 8'd2,   16'd256};
    vecs[5] = '{1, 8'd200, 8'd3,   16'd600};
    vecs[6] = '{0, 8'd17,  8'd15,  16'd255};
    vecs[7] = '{3, 8'd255, 8'd1,   16'd255};

    rst = 1'b1;
    req_valid = 4'b0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_res_valid", {31'b0, res_valid}, 0);
    check("rst_res_p", {16'b0, res_p}, 0);
    check("rst_res_id", {30'b0, res_id}, 0);
    check("rst_req_ready", {28'b0, req_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);

    // table-driven single requests
    for (int v = 0; v < 8; v++) begin
      @(posedge clk);
      #1;
      set_lane(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = 4'b1 << vecs[v].id;
      wait_grant(idx, waited);
      check("vec_grant", idx, vecs[v].id);
      @(posedge clk);
      #1 req_valid = 4'b0;
      wait_result();
      check("vec_p", {16'b0, res_p}, {16'b0, vecs[v].p});
      check("vec_id", {30'b0, res_id}, vecs[v].id);
    end

    // all four valid from reset: 0,1,2,3,0 every 3 cycles, first grant right after reset
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 8'(10 + i), 8'(20 + 7*i));
    req_valid = 4'hf;
    @(posedge clk);
    #1 rst = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(idx, waited);
      check("rr_order", idx, k % 4);
      if (k == 0) check("rr_first_cycle", waited, 1);
      else check("rr_interval", int'($realtime - t_prev), 30);
      t_prev = $realtime;
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_result();

    // fairness: requesters 1 and 3 held valid
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_lane(1, 8'd99, 8'd3);
    set_lane(3, 8'd250, 8'd250);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_grant(idx, waited);
      check("fair_order", idx, (k % 2 == 0) ? 1 : 3);
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_result();

    // backpressure: hold result 5 cycles with another requester waiting
    @(posedge clk);
    #1 res_ready = 1'b0;
    set_lane(1, 8'd50, 8'd60);
    req_valid = 4'b0010;
    wait_grant(idx, waited);
    check("bp_grant", idx, 1);
    @(posedge clk);
    #1;
    set_lane(2, 8'd7, 8'd9);
    req_valid = 4'b0100;
    wait_result();
    held_p = res_p;
    check("bp_p", {16'b0, held_p}, 3000);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, res_valid}, 1);
      check("bp_hold_p", {16'b0, res_p}, 3000);
      check("bp_hold_id", {30'b0, res_id}, 1);
      check("bp_ready", {28'b0, req_ready}, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    check("bp_no_grant_on_consume", {28'b0, req_ready}, 0);
    @(negedge clk);
    check("bp_next_grant", {28'b0, req_ready}, 4'b0100);
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_result();

    // reset while in CALC: abandoned, pointer back to 0
    @(posedge clk);
    #1;
    set_lane(1, 8'd77, 8'd77);
    req_valid = 4'b0010;
    wait_grant(idx, waited);
    check("mid_grant", idx, 1);
    @(posedge clk);
    #1;
    req_valid = 4'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy_calc", {31'b0, busy}, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_lane(2, 8'd4, 8'd5);
    req_valid = 4'b0110;
    @(negedge clk);
    check("mid_res_valid", {31'b0, res_valid}, 0);
    check("mid_busy", {31'b0, busy}, 0);
    check("mid_ptr_zero", {28'b0, req_ready}, 4'b0010);
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_result();
    check("mid_new_p", {16'b0, res_p}, 5929);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
